// File: rtl/cntr_dn_seq.sv
`default_nettype none
// ============================================================================
// Module   : cntr_dn_seq
// Brief    : Loadable down-counting round sequencer for the iterative CORDIC
//            datapath; exports remaining count, ascending round index,
//            busy/last flags and a one-cycle completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module cntr_dn_seq #(
    parameter int RNDW = 4
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            start,
    input  logic [RNDW-1:0] ld_val,
    input  logic            c_dn,
    input  logic            abort,
    output logic [RNDW-1:0] q,
    output logic [RNDW-1:0] rnd,
    output logic            busy,
    output logic            last,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RNDW-1:0] cnt_q, cnt_d;
    logic [RNDW-1:0] nlat_q, nlat_d;
    logic            busy_q, done_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nlat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nlat_q  <= nlat_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nlat_d  = nlat_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            nlat_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        cnt_d   = ld_val;
                        nlat_d  = ld_val;
                    end
                end
                S_RUN: begin
                    // The strobe that finds the count already at zero is the final round.
                    if (c_dn) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d = S_RUN;
                        cnt_d   = ld_val;
                        nlat_d  = ld_val;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign q    = cnt_q;
    assign rnd  = nlat_q - cnt_q;
    assign busy = busy_q;
    assign last = busy_q && (cnt_q == '0);
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cntr_dn_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cntr_dn_seq
// Brief    : Self-checking bench for cntr_dn_seq: vector table, directed
//            corner sequences and random traffic against a round-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cntr_dn_seq;

    localparam int C_RNDW = 4;

    logic              clk = 1'b0;
    logic              clr_n;
    logic              start;
    logic [C_RNDW-1:0] ld_val;
    logic              c_dn;
    logic              abort;
    logic [C_RNDW-1:0] q;
    logic [C_RNDW-1:0] rnd;
    logic              busy;
    logic              last;
    logic              done;

    int total = 0;
    int bad   = 0;

    // Model: a sequence of n+1 rounds, k strobes consumed so far.
    bit m_run, m_done;
    int m_n, m_k;

    always #5 clk = ~clk;

    cntr_dn_seq #(.RNDW(C_RNDW)) u_dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .start  (start),
        .ld_val (ld_val),
        .c_dn   (c_dn),
        .abort  (abort),
        .q      (q),
        .rnd    (rnd),
        .busy   (busy),
        .last   (last),
        .done   (done)
    );

    typedef struct {
        logic              s;
        logic [C_RNDW-1:0] l;
        logic              c;
        logic              a;
        logic [C_RNDW-1:0] eq;
        logic [C_RNDW-1:0] er;
        logic              eb;
        logic              el;
        logic              ed;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_n = 0; m_k = 0;
    endtask

    task automatic model_step(input logic s, input logic [C_RNDW-1:0] l,
                              input logic c, input logic a);
        if (a) begin
            model_reset();
        end else if (!m_run && s) begin
            m_run = 1; m_done = 0; m_n = int'(l); m_k = 0;
        end else if (m_run) begin
            if (c) begin
                m_k++;
                if (m_k == m_n + 1) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end else begin
            m_done = 0;
        end
    endtask

    task automatic check_model();
        int used;
        used = (m_k > m_n) ? m_n : m_k;
        chk("q",    32'(q),    32'(m_n - used));
        chk("rnd",  32'(rnd),  32'(used));
        chk("busy", 32'(busy), 32'(m_run));
        chk("last", 32'(last), 32'(m_run && (m_k == m_n)));
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic cyc(input logic s, input logic [C_RNDW-1:0] l,
                       input logic c, input logic a);
        start = s; ld_val = l; c_dn = c; abort = a;
        @(posedge clk);
        model_step(s, l, c, a);
        @(negedge clk);
        check_model();
    endtask

    task automatic chk_out(input string nm, input logic [C_RNDW-1:0] eq,
                           input logic [C_RNDW-1:0] er, input logic eb,
                           input logic el, input logic ed);
        chk({nm, "_q"},    32'(q),    32'(eq));
        chk({nm, "_rnd"},  32'(rnd),  32'(er));
        chk({nm, "_busy"}, 32'(busy), 32'(eb));
        chk({nm, "_last"}, 32'(last), 32'(el));
        chk({nm, "_done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        vec_t tbl[8];
        int   max_rnd;
        int   cnt_busy;

        clr_n = 1'b0; start = 1'b0; ld_val = '0; c_dn = 1'b0; abort = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_out("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;

        // Basic sequence ld_val=3, c_dn held high
        tbl[0] = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 4'd9, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].s, tbl[i].l, tbl[i].c, tbl[i].a);
            chk_out($sformatf("vec%0d", i), tbl[i].eq, tbl[i].er, tbl[i].eb,
                    tbl[i].el, tbl[i].ed);
        end

        // ld_val=5 with sparse strobes
        cyc(1'b1, 4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) cyc(1'b0, 4'd0, (i % 3) == 0, 1'b0);
        chk_out("sparse_end", 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);

        // Single round, stray strobe in IDLE, then back-to-back start in DONE
        cyc(1'b1, 4'd0, 1'b0, 1'b0);
        chk_out("one_run", 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("one_done", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("idle_strobe", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        cyc(1'b1, 4'd2, 1'b0, 1'b0);
        chk_out("b2b", 4'd2, 4'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("b2b_done", 4'd0, 4'd2, 1'b0, 1'b0, 1'b1);

        // Abort at q=2 of ld_val=7, then abort+start in IDLE
        cyc(1'b1, 4'd7, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("pre_abort", 4'd2, 4'd5, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, 1'b1);
        chk_out("abort", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'd6, 1'b0, 1'b1);
        chk_out("abort_start", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("abort_after", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN
        cyc(1'b1, 4'd7, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 4'd0, 1'b1, 1'b0);
        #2 clr_n = 1'b0;
        #1 chk_out("async_rst", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_out("rst_hold", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;

        // Full range ld_val=15
        cyc(1'b1, 4'd15, 1'b0, 1'b0);
        max_rnd  = 0;
        cnt_busy = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy) cnt_busy++;
            if (int'(rnd) > max_rnd) max_rnd = int'(rnd);
            cyc(1'b0, 4'd0, 1'b1, 1'b0);
        end
        chk("full_max_rnd", 32'(max_rnd), 32'd15);
        chk("full_busy_cycles", 32'(cnt_busy), 32'd16);
        chk_out("full_done", 4'd0, 4'd15, 1'b0, 1'b0, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) == 0), C_RNDW'($urandom),
                $urandom_range(0, 1) == 1, ($urandom_range(0, 40) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cntr_dn_seq.md
Name: cntr_dn_seq

Overview:
Loadable down-counting round sequencer for the iterative CORDIC datapath. It complements the free-running up counter.
- Loads a round count on a start handshake and counts down once per advance strobe.
- Exports the remaining-count value and the derived ascending round index, which serves as the shift amount.
- Signals last-round and completion to the datapath controller.
- Supports synchronous abort.

Parameters:
rndw, 4, width of round count, remaining-count and round-index buses.

Ports:
clk  input  1  rising-edge clock.
clr_n  input  1  asynchronous active-low reset.
start  input  1  request to begin a sequence; accepted only in IDLE or DONE.
ld_val  input  rndw  number of rounds minus one; sampled on the accepted start.
c_dn  input  1  advance strobe; one round consumed per cycle high in RUN.
abort  input  1  synchronous abort; highest priority after reset.
q  output  rndw  remaining count (registered).
rnd  output  rndw  ascending round index = n_lat - q, modulo 2^rndw (combinational from registers).
busy  output  1  high while in RUN.
last  output  1  busy && (q == 0).
done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (clr_n low, asynchronous): state IDLE, q=0, n_lat=0, busy=0, done=0. Consequently rnd=0 and last=0. Reset is released synchronously by the external reset synchroniser.
- States: IDLE, RUN, DONE. busy is a registered flag equal to (state==RUN). done is a registered flag equal to (state==DONE).
- Priority each cycle: abort > start-accept > c_dn.
- IDLE:
  - start=1 → next cycle state RUN, q=ld_val, n_lat=ld_val.
  - c_dn is ignored.
- RUN:
  - start is ignored.
  - c_dn=1 and q!=0 → q<=q-1.
  - c_dn=1 and q==0 → state DONE; q stays 0.
  - c_dn=0 → hold all registers.
  - Any number of idle cycles between strobes is allowed.
- DONE (exactly one cycle, done=1):
  - start=1 → RUN with new ld_val (back-to-back sequences, no bubble beyond the DONE cycle).
  - otherwise → IDLE.
  - q and n_lat hold in DONE, then hold in IDLE until the next start.
- Round count: a sequence with ld_val=N consumes exactly N+1 c_dn strobes in RUN.
  - busy is high from the cycle after start through the cycle containing the final strobe.
  - done asserts the cycle after the final strobe.
  - ld_val=0 gives a single round: last=1 in the first RUN cycle.
- rnd runs 0,1,…,N across the sequence. The subtraction is rndw bits and never wraps while RUN, since q≤n_lat.
- abort=1 in any state → next cycle IDLE, q=0, n_lat=0, busy=0, no done pulse. abort together with start: abort wins and start is dropped.
- Full range: ld_val=2^rndw-1 runs 2^rndw rounds with no overflow; q never decrements below 0.
- Reset mid-RUN clears immediately and no done is emitted.

Test Plan:
1. Reset, then start with ld_val=3, then c_dn held high → q=3,2,1,0 with rnd=0,1,2,3; last high only at q=0; done high one cycle after the 4th strobe; busy high for exactly 4 cycles.
2. ld_val=5 with c_dn toggled 1,0,0,1,… → q decrements only on strobe cycles; done asserts only after the 6th strobe.
3. ld_val=0, one strobe → busy and last high for 1 cycle, then done; a second strobe while IDLE leaves q=0 and produces no done.
4. Start asserted during the DONE cycle with ld_val=2 → RUN the next cycle with q=2, rnd=0; no IDLE cycle between sequences.
5. abort asserted at q=2 during ld_val=7 → next cycle IDLE, q=0, busy=0, no done pulse; start asserted with abort in IDLE is ignored.
6. clr_n pulled low asynchronously mid-RUN, and ld_val=15 (rndw=4) run to completion → outputs clear without a clock edge; the full run gives 16 strobes, rnd reaches 15, and q never wraps.
